// File: rtl/txd_word_arbiter.sv
// Round-robin arbiter that shares one uart_txd byte transmitter among NUM_REQ
// 32-bit word sources, sending each granted word MSB byte first.
module txd_word_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     req_err,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic [7:0]             txd_byte,
   output logic                   txd_start,
   input  logic                   txd_done
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, ACK, ERR} state_t;

   state_t          state;
   logic [2:0]      rr_ptr;
   logic [1:0]      byte_cnt;
   logic [TW-1:0]   timer;
   logic [31:0]     word;
   logic            done_prev;
   logic            done_rise;
   logic [7:0]      valid_ext;
   logic [255:0]    data_ext;
   logic [3:0]      cand;
   logic            pick_found;
   logic [2:0]      pick_id;
   logic [2:0]      next_ptr;

   assign done_rise = txd_done & ~done_prev;
   assign valid_ext = 8'(req_valid);
   assign data_ext  = 256'(req_data);
   assign next_ptr  = (grant_id == 3'(NUM_REQ-1)) ? 3'd0 : grant_id + 3'd1;

   // First requesting source at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = 3'd0;
      cand       = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + 4'(i);
         if (cand >= 4'(NUM_REQ))
            cand = cand - 4'(NUM_REQ);
         if (!pick_found && valid_ext[cand[2:0]]) begin
            pick_found = 1'b1;
            pick_id    = cand[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= 3'd0;
         byte_cnt  <= 2'd0;
         timer     <= '0;
         word      <= 32'd0;
         done_prev <= 1'b0;
         req_ack   <= '0;
         req_err   <= '0;
         grant_id  <= 3'd0;
         busy      <= 1'b0;
         txd_byte  <= 8'd0;
         txd_start <= 1'b0;
      end else begin
         done_prev <= txd_done;
         txd_start <= 1'b0;
         req_ack   <= '0;
         req_err   <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_id;
                  word     <= data_ext[{pick_id, 5'b0} +: 32];
                  byte_cnt <= 2'd0;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               case (byte_cnt)
                  2'd0:    txd_byte <= word[31:24];
                  2'd1:    txd_byte <= word[23:16];
                  2'd2:    txd_byte <= word[15:8];
                  default: txd_byte <= word[7:0];
               endcase
               state <= START;
            end
            START: begin
               txd_start <= 1'b1;
               timer     <= '0;
               state     <= WAIT;
            end
            // A stale high txd_done level never counts; only a fresh rise does.
            WAIT: begin
               if (done_rise) begin
                  if (byte_cnt == 2'd3) begin
                     req_ack <= ONE_HOT0 << grant_id;
                     state   <= ACK;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                     state    <= LOAD;
                  end
               end else if (timer == TW'(TIMEOUT_CYC-1)) begin
                  req_err <= ONE_HOT0 << grant_id;
                  state   <= ERR;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ACK, ERR: begin
               rr_ptr <= next_ptr;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_txd_word_arbiter.sv
// Directed bench for txd_word_arbiter: a small uart_txd responder model drives
// txd_done, and each scenario task checks bytes, grants, acks and errors.
module tb_txd_word_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_valid2;
   logic [32*N-1:0] req_data, req_data2;
   logic [N-1:0]    req_ack, req_err, req_ack2, req_err2;
   logic [2:0]      grant_id, grant_id2;
   logic            busy, busy2;
   logic [7:0]      txd_byte, txd_byte2;
   logic            txd_start, txd_start2;
   logic            txd_done, txd_done2;

   int checks = 0;
   int errors = 0;

   logic [7:0]   byte_q[$];
   logic [N-1:0] ack_q[$];
   logic [N-1:0] err_q[$];
   logic [2:0]   gid_q[$];

   bit model_en;
   int model_delay, model_hold;
   int cyc, rise_at, hold_end;

   always #5 clk = ~clk;

   txd_word_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(20000)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ack(req_ack), .req_err(req_err), .grant_id(grant_id), .busy(busy),
      .txd_byte(txd_byte), .txd_start(txd_start), .txd_done(txd_done));

   txd_word_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut_to (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
      .req_ack(req_ack2), .req_err(req_err2), .grant_id(grant_id2), .busy(busy2),
      .txd_byte(txd_byte2), .txd_start(txd_start2), .txd_done(txd_done2));

   // Transmitter model: txd_done rises model_delay cycles after each txd_start
   // and stays high for model_hold cycles.
   initial begin
      txd_done = 1'b0;
      cyc      = 0;
      rise_at  = -1;
      hold_end = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (model_en && txd_start)
            rise_at = cyc + model_delay;
         if (cyc == rise_at)
            hold_end = cyc + model_hold;
         txd_done = (cyc < hold_end);
      end
   end

   task automatic clear_q;
      byte_q.delete();
      ack_q.delete();
      err_q.delete();
      gid_q.delete();
   endtask

   task automatic do_reset;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Collect starts/acks/errors until n_ev ack+err events or n_st starts.
   task automatic run(input int n_ev, input int n_st, input logic [N-1:0] drop_mask,
                      input int budget);
      int ev = 0;
      int st = 0;
      for (int c = 0; c < budget && ev < n_ev && st < n_st; c++) begin
         @(negedge clk);
         if (txd_start) begin byte_q.push_back(txd_byte); st++; end
         if (|req_ack) begin ack_q.push_back(req_ack); gid_q.push_back(grant_id); ev++; end
         if (|req_err) begin err_q.push_back(req_err); ev++; end
         req_valid = req_valid & ~(drop_mask & (req_ack | req_err));
      end
      checks++;
      if (ev < n_ev && st < n_st) begin
         errors++;
         $display("[TB] FAIL run_budget: got %0d events %0d starts, required %0d events or %0d starts",
                  ev, st, n_ev, n_st);
      end
   endtask

   task automatic test_reset;
      bit bad = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, txd_start, txd_byte, req_ack, req_err, grant_id} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h required 0",
                  {busy, txd_start, txd_byte, req_ack, req_err, grant_id});
      end
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || txd_start !== 1'b0 || busy2 !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("[TB] FAIL reset_idle: got activity with no request, required busy=0");
      end
   endtask

   task automatic test_single_word;
      logic [7:0] exp[3] = '{8'hB2, 8'hC3, 8'hD4};
      do_reset;
      clear_q;
      model_en = 1; model_delay = 50; model_hold = 1;
      req_data[31:0] = 32'hA1B2C3D4;
      req_valid = 3'b001;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 3'd0) begin
         errors++;
         $display("[TB] FAIL single_grant: got busy=%b id=%0d, required busy=1 id=0", busy, grant_id);
      end
      @(negedge clk);
      checks++;
      if (txd_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_early_start: got txd_start=%b, required 0", txd_start);
      end
      @(negedge clk);
      checks++;
      if (txd_start !== 1'b1 || txd_byte !== 8'hA1) begin
         errors++;
         $display("[TB] FAIL single_first_byte: got start=%b byte=%h, required 1 A1", txd_start, txd_byte);
      end
      run(1, 1000, 3'b001, 1000);
      checks++;
      if (byte_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL single_byte_count: got %0d, required 3", byte_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (byte_q[i] !== exp[i]) begin
               errors++;
               $display("[TB] FAIL single_byte%0d: got %h, required %h", i + 1, byte_q[i], exp[i]);
            end
         end
      end
      checks++;
      if (ack_q.size() != 1 || err_q.size() != 0 || (ack_q.size() == 1 && ack_q[0] !== 3'b001)) begin
         errors++;
         $display("[TB] FAIL single_ack: got %0d acks %0d errs, required one ack 001",
                  ack_q.size(), err_q.size());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_idle: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_round_robin;
      logic [2:0] exp[6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
      logic [7:0] top;
      do_reset;
      clear_q;
      model_en = 1; model_delay = 5; model_hold = 1;
      req_data = {32'h30AABB03, 32'h20AABB02, 32'h10AABB01};
      req_valid = 3'b111;
      run(6, 1000, 3'b000, 2000);
      req_valid = 3'b000;
      checks++;
      if (gid_q.size() != 6 || byte_q.size() != 24) begin
         errors++;
         $display("[TB] FAIL rr_counts: got %0d acks %0d bytes, required 6 and 24",
                  gid_q.size(), byte_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            top = 8'h10 * (8'(exp[i]) + 8'd1);
            checks++;
            if (gid_q[i] !== exp[i] || ack_q[i] !== (3'b001 << exp[i]) || byte_q[4*i] !== top) begin
               errors++;
               $display("[TB] FAIL rr_word%0d: got id=%0d ack=%b top=%h, required id=%0d ack=%b top=%h",
                        i, gid_q[i], ack_q[i], byte_q[4*i], exp[i], 3'b001 << exp[i], top);
            end
         end
      end
   endtask

   task automatic test_long_done;
      logic [7:0] exp[4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
      do_reset;
      clear_q;
      model_en = 1; model_delay = 20; model_hold = 10;
      req_data[95:64] = 32'h0F1E2D3C;
      req_valid = 3'b100;
      run(1, 1000, 3'b100, 1000);
      checks++;
      if (byte_q.size() != 4) begin
         errors++;
         $display("[TB] FAIL long_byte_count: got %0d, required 4", byte_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (byte_q[i] !== exp[i]) begin
               errors++;
               $display("[TB] FAIL long_byte%0d: got %h, required %h", i, byte_q[i], exp[i]);
            end
         end
      end
      checks++;
      if (ack_q.size() != 1 || (ack_q.size() == 1 && (ack_q[0] !== 3'b100 || gid_q[0] !== 3'd2))) begin
         errors++;
         $display("[TB] FAIL long_ack: got %0d acks, required one ack 100 id 2", ack_q.size());
      end
   endtask

   task automatic test_timeout;
      int  t = 0;
      bit  seen = 0;
      bit  any_ack = 0;
      req_data2  = {32'h00000000, 32'hCAFEF00D, 32'h01020304};
      req_valid2 = 3'b011;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (txd_start2) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL to_start: got no txd_start, required one within 20 cycles");
      end
      seen = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (|req_ack2) any_ack = 1;
         if (|req_err2) begin seen = 1; t = c; end
      end
      checks++;
      if (t != 16) begin
         errors++;
         $display("[TB] FAIL to_latency: got %0d cycles, required 16", t);
      end
      checks++;
      if (req_err2 !== 3'b001) begin
         errors++;
         $display("[TB] FAIL to_err0: got %b, required 001", req_err2);
      end
      req_valid2 = 3'b010;
      repeat (2) @(negedge clk);
      checks++;
      if (busy2 !== 1'b1 || grant_id2 !== 3'd1) begin
         errors++;
         $display("[TB] FAIL to_next_grant: got busy=%b id=%0d, required 1 1", busy2, grant_id2);
      end
      seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (|req_ack2) any_ack = 1;
         if (|req_err2) seen = 1;
      end
      checks++;
      if (req_err2 !== 3'b010) begin
         errors++;
         $display("[TB] FAIL to_err1: got %b, required 010", req_err2);
      end
      req_valid2 = 3'b000;
      checks++;
      if (any_ack) begin
         errors++;
         $display("[TB] FAIL to_no_ack: got an ack, required none");
      end
   endtask

   task automatic test_mid_word;
      logic [7:0] exp[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      bit bad = 0;
      do_reset;
      clear_q;
      model_en = 1; model_delay = 10; model_hold = 1;
      req_data[63:32] = 32'hDEADBEEF;
      req_valid = 3'b010;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 3'd1) begin
         errors++;
         $display("[TB] FAIL mid_grant: got busy=%b id=%0d, required 1 1", busy, grant_id);
      end
      req_data[63:32] = 32'h12345678;
      req_valid = 3'b000;
      run(1, 1000, 3'b000, 1000);
      checks++;
      if (byte_q.size() != 4) begin
         errors++;
         $display("[TB] FAIL mid_byte_count: got %0d, required 4", byte_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (byte_q[i] !== exp[i]) begin
               errors++;
               $display("[TB] FAIL mid_byte%0d: got %h, required %h", i, byte_q[i], exp[i]);
            end
         end
      end
      checks++;
      if (ack_q.size() != 1 || (ack_q.size() == 1 && ack_q[0] !== 3'b010)) begin
         errors++;
         $display("[TB] FAIL mid_ack: got %0d acks, required one ack 010", ack_q.size());
      end

      clear_q;
      req_data[63:32] = 32'h55AA33CC;
      req_valid = 3'b010;
      run(100, 3, 3'b010, 500);
      checks++;
      if (byte_q.size() != 3 || byte_q[2] !== 8'h33 || ack_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL mid_pre_reset: got %0d bytes %0d acks, required 3 bytes ending 33, 0 acks",
                  byte_q.size(), ack_q.size());
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, txd_start, txd_byte, req_ack, req_err, grant_id} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_async_reset: got %h required 0",
                  {busy, txd_start, txd_byte, req_ack, req_err, grant_id});
      end
      req_valid = 3'b000;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (busy || txd_start || (|req_ack) || (|req_err)) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("[TB] FAIL mid_post_reset: got activity after reset, required idle");
      end
   endtask

   initial begin
      rst        = 1'b0;
      req_valid  = '0;
      req_valid2 = '0;
      req_data   = '0;
      req_data2  = '0;
      txd_done2  = 1'b0;
      model_en   = 0;
      model_delay = 10;
      model_hold  = 1;
      $display("[TB] txd_word_arbiter bench start");
      test_reset;
      test_single_word;
      test_round_robin;
      test_long_done;
      test_timeout;
      test_mid_word;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
